// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU pipeline definitions: writeback-select codes, the RV32 opcodes
// that decide whether an instruction reads rs1/rs2, the ID/EX register record
// and its bubble value, plus helpers that decode source-register usage.
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Writeback-select codes carried with each instruction
   localparam logic [1:0] WD_RETURN_PC  = 2'b00;
   localparam logic [1:0] WD_ALU_RESULT = 2'b01;
   localparam logic [1:0] WD_MEM_DATA   = 2'b10;

   // Opcodes that matter for source-register usage
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;

   // Contents of the ID/EX pipeline register
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ext;
      logic [4:0]  rd;
      logic [1:0]  wd_sel;
      logic        we;
      logic        mem_we;
      logic [3:0]  alu_op;
      logic        alu_b_sel;
      logic        branch;
   } id_ex_t;

   // A bubble is an all-zero record: invalid, no register or memory write
   localparam id_ex_t ID_EX_BUBBLE = '0;

   // U-type and JAL have no rs1 field; everything else reads rs1
   function automatic logic rs1_used(input logic [6:0] opcode);
      return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   endfunction

   // Only R, S and B formats read rs2
   function automatic logic rs2_used(input logic [6:0] opcode);
      return (opcode == OP_R || opcode == OP_S || opcode == OP_B);
   endfunction

endpackage

// File: rtl/id_ex_if.sv
// ---------------------------------------------------------------------------
// id_ex_if
// Decode-to-execute bundle: the ID-stage instruction, operands and control
// going in, and the registered ID/EX contents coming out.
//   master : decode side, drives id_*, observes ex_*
//   slave  : id_ex_stage, consumes id_*, drives ex_*
// ---------------------------------------------------------------------------
interface id_ex_if;

   // ID-stage instruction, operands and control
   logic        id_valid_i;
   logic [31:0] id_pc_i;
   logic [31:0] id_inst_i;
   logic [31:0] id_rD1_i;
   logic [31:0] id_rD2_i;
   logic [31:0] id_ext_i;
   logic [1:0]  id_wd_sel_i;
   logic        id_we_i;
   logic        id_mem_we_i;
   logic [3:0]  id_alu_op_i;
   logic        id_alu_b_sel_i;
   logic        id_branch_i;

   // Registered ID/EX contents
   logic        ex_valid_o;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_rD1_o;
   logic [31:0] ex_rD2_o;
   logic [31:0] ex_ext_o;
   logic [4:0]  ex_rd_o;
   logic [1:0]  ex_wd_sel_o;
   logic        ex_we_o;
   logic        ex_mem_we_o;
   logic [3:0]  ex_alu_op_o;
   logic        ex_alu_b_sel_o;
   logic        ex_branch_o;

   modport master (
      output id_valid_i, id_pc_i, id_inst_i, id_rD1_i, id_rD2_i, id_ext_i,
             id_wd_sel_i, id_we_i, id_mem_we_i, id_alu_op_i, id_alu_b_sel_i,
             id_branch_i,
      input  ex_valid_o, ex_pc_o, ex_rD1_o, ex_rD2_o, ex_ext_o, ex_rd_o,
             ex_wd_sel_o, ex_we_o, ex_mem_we_o, ex_alu_op_o, ex_alu_b_sel_o,
             ex_branch_o
   );

   modport slave (
      input  id_valid_i, id_pc_i, id_inst_i, id_rD1_i, id_rD2_i, id_ext_i,
             id_wd_sel_i, id_we_i, id_mem_we_i, id_alu_op_i, id_alu_b_sel_i,
             id_branch_i,
      output ex_valid_o, ex_pc_o, ex_rD1_o, ex_rD2_o, ex_ext_o, ex_rd_o,
             ex_wd_sel_o, ex_we_o, ex_mem_we_o, ex_alu_op_o, ex_alu_b_sel_o,
             ex_branch_o
   );

endinterface

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
// Purely combinational. Compares the decode-stage source registers against
// the instructions in EX and MEM, selects a bypass value (EX has priority)
// and raises a one-cycle stall when the EX producer is a load.
// Ports:
//   i_opcode, i_rs1, i_rs2      decode-stage opcode and source registers
//   i_ex_*                      registered ID/EX producer info + ALU result
//   i_mem_*                     MEM-stage producer info and candidate data
//   i_flush                     taken branch/jump in EX, suppresses stall
//   o_fwd1/o_fwd2, o_r1/2_select operand override toward decode
//   o_stall                     load-use stall request
// Writeback-stage producers are not examined: the register file resolves
// them by writing before reading.
// ---------------------------------------------------------------------------
module hazard_forward_unit
   import cpu_pkg::*;
#(
   parameter logic [1:0] RETURN_PC  = WD_RETURN_PC,
   parameter logic [1:0] ALU_RESULT = WD_ALU_RESULT,
   parameter logic [1:0] MEM_DATA   = WD_MEM_DATA
) (
   input  logic [6:0]  i_opcode,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic        i_ex_valid,
   input  logic        i_ex_we,
   input  logic [4:0]  i_ex_rd,
   input  logic [1:0]  i_ex_wd_sel,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_ex_result,
   input  logic [4:0]  i_mem_rd,
   input  logic        i_mem_we,
   input  logic [1:0]  i_mem_wd_sel,
   input  logic [31:0] i_mem_alu_result,
   input  logic [31:0] i_mem_return_pc,
   input  logic [31:0] i_mem_data,
   input  logic        i_flush,
   output logic [31:0] o_fwd1,
   output logic [31:0] o_fwd2,
   output logic        o_r1_select,
   output logic        o_r2_select,
   output logic        o_stall
);

   logic        w_rs1_used, w_rs2_used;
   logic        w_ex_writes, w_mem_writes;
   logic        w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
   logic        w_ex_is_load;
   logic [31:0] w_ex_data, w_mem_data;

   assign w_rs1_used = rs1_used(i_opcode);
   assign w_rs2_used = rs2_used(i_opcode);

   // x0 is hard-wired to zero, so a producer targeting it is never a source
   assign w_ex_writes  = i_ex_valid & i_ex_we & (i_ex_rd != 5'd0);
   assign w_mem_writes = i_mem_we & (i_mem_rd != 5'd0);

   assign w_ex_hit1  = w_ex_writes  & (i_ex_rd  == i_rs1) & w_rs1_used;
   assign w_ex_hit2  = w_ex_writes  & (i_ex_rd  == i_rs2) & w_rs2_used;
   assign w_mem_hit1 = w_mem_writes & (i_mem_rd == i_rs1) & w_rs1_used;
   assign w_mem_hit2 = w_mem_writes & (i_mem_rd == i_rs2) & w_rs2_used;

   assign w_ex_is_load = (i_ex_wd_sel == MEM_DATA);

   // Value the EX producer will eventually write back, if known this cycle
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_ex_data = 32'd0;
      case (i_ex_wd_sel)
         ALU_RESULT: w_ex_data = i_ex_result;
         RETURN_PC:  w_ex_data = i_ex_pc + 32'd4;
         default:    w_ex_data = 32'd0;
      endcase
   end

   always_comb begin
      w_mem_data = 32'd0;
      case (i_mem_wd_sel)
         RETURN_PC:  w_mem_data = i_mem_return_pc;
         ALU_RESULT: w_mem_data = i_mem_alu_result;
         MEM_DATA:   w_mem_data = i_mem_data;
         default:    w_mem_data = 32'd0;
      endcase
   end

   // An EX match always masks a MEM match (it is the younger write). When
   // the EX producer is a load its data does not exist yet: no override is
   // offered and the stall holds decode for one cycle instead.
   always_comb begin
      o_r1_select = 1'b0;
      o_fwd1      = 32'd0;
      o_r2_select = 1'b0;
      o_fwd2      = 32'd0;
      if (w_ex_hit1) begin
         if (!w_ex_is_load) begin
            o_r1_select = 1'b1;
            o_fwd1      = w_ex_data;
         end
      end else if (w_mem_hit1) begin
         o_r1_select = 1'b1;
         o_fwd1      = w_mem_data;
      end
      if (w_ex_hit2) begin
         if (!w_ex_is_load) begin
            o_r2_select = 1'b1;
            o_fwd2      = w_ex_data;
         end
      end else if (w_mem_hit2) begin
         o_r2_select = 1'b1;
         o_fwd2      = w_mem_data;
      end
   end

   // A flush discards the dependent instruction anyway, so it cancels the stall
   assign o_stall = (w_ex_hit1 | w_ex_hit2) & w_ex_is_load & ~i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding, load-use stall and a
// saturating stall counter.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-low reset
//   id_bus (slave)          ID-stage fields in, registered ID/EX fields out
//   ex_result_i             combinational ALU result of the EX instruction
//   mem_*                   MEM-stage writeback info for forwarding
//   flush_i                 taken branch/jump resolved in EX
//   forward_data_*_o, r*_select_o   operand override to decode
//   stall_o                 hold PC and IF/ID for one cycle
//   stall_cnt_o             number of load-use stall cycles taken
// A stalled or flushed cycle, or an invalid ID slot, loads a bubble.
// ---------------------------------------------------------------------------
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter logic [1:0] RETURN_PC  = WD_RETURN_PC,
   parameter logic [1:0] ALU_RESULT = WD_ALU_RESULT,
   parameter logic [1:0] MEM_DATA   = WD_MEM_DATA
) (
   input  logic        clk_i,
   input  logic        reset_i,
   id_ex_if.slave      id_bus,
   input  logic [31:0] ex_result_i,
   input  logic [4:0]  mem_rd_i,
   input  logic        mem_we_i,
   input  logic [1:0]  mem_wd_sel_i,
   input  logic [31:0] mem_alu_result_i,
   input  logic [31:0] mem_return_pc_i,
   input  logic [31:0] mem_data_i,
   input  logic        flush_i,
   output logic [31:0] forward_data_1_o,
   output logic [31:0] forward_data_2_o,
   output logic        r1_select_o,
   output logic        r2_select_o,
   output logic        stall_o,
   output logic [31:0] stall_cnt_o
);

   id_ex_t      r_ex;
   id_ex_t      w_ex_next;
   logic [31:0] r_stall_cnt;
   logic        w_stall;
   logic        w_unused_inst;

   hazard_forward_unit #(
      .RETURN_PC  (RETURN_PC),
      .ALU_RESULT (ALU_RESULT),
      .MEM_DATA   (MEM_DATA)
   ) u_hazard (
      .i_opcode         (id_bus.id_inst_i[6:0]),
      .i_rs1            (id_bus.id_inst_i[19:15]),
      .i_rs2            (id_bus.id_inst_i[24:20]),
      .i_ex_valid       (r_ex.valid),
      .i_ex_we          (r_ex.we),
      .i_ex_rd          (r_ex.rd),
      .i_ex_wd_sel      (r_ex.wd_sel),
      .i_ex_pc          (r_ex.pc),
      .i_ex_result      (ex_result_i),
      .i_mem_rd         (mem_rd_i),
      .i_mem_we         (mem_we_i),
      .i_mem_wd_sel     (mem_wd_sel_i),
      .i_mem_alu_result (mem_alu_result_i),
      .i_mem_return_pc  (mem_return_pc_i),
      .i_mem_data       (mem_data_i),
      .i_flush          (flush_i),
      .o_fwd1           (forward_data_1_o),
      .o_fwd2           (forward_data_2_o),
      .o_r1_select      (r1_select_o),
      .o_r2_select      (r2_select_o),
      .o_stall          (w_stall)
   );

   assign stall_o = w_stall;

   // funct3/funct7 only matter to the ALU decoder, not to this stage
   assign w_unused_inst = ^{id_bus.id_inst_i[31:25], id_bus.id_inst_i[14:12]};

   // Next ID/EX contents: bubble unless a valid instruction advances
   always_comb begin
      w_ex_next = ID_EX_BUBBLE;
      if (id_bus.id_valid_i && !flush_i && !w_stall) begin
         w_ex_next.valid     = 1'b1;
         w_ex_next.pc        = id_bus.id_pc_i;
         w_ex_next.rd1       = r1_select_o ? forward_data_1_o : id_bus.id_rD1_i;
         w_ex_next.rd2       = r2_select_o ? forward_data_2_o : id_bus.id_rD2_i;
         w_ex_next.ext       = id_bus.id_ext_i;
         w_ex_next.rd        = id_bus.id_inst_i[11:7];
         w_ex_next.wd_sel    = id_bus.id_wd_sel_i;
         w_ex_next.we        = id_bus.id_we_i;
         w_ex_next.mem_we    = id_bus.id_mem_we_i;
         w_ex_next.alu_op    = id_bus.id_alu_op_i;
         w_ex_next.alu_b_sel = id_bus.id_alu_b_sel_i;
         w_ex_next.branch    = id_bus.id_branch_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block order.
      if (!reset_i) begin
         r_ex <= ID_EX_BUBBLE;
      end else begin
         r_ex <= w_ex_next;
      end
   end

   // Stall already excludes flush cycles; the counter sticks at all-ones
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_stall_cnt <= 32'd0;
      end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;

   assign id_bus.ex_valid_o     = r_ex.valid;
   assign id_bus.ex_pc_o        = r_ex.pc;
   assign id_bus.ex_rD1_o       = r_ex.rd1;
   assign id_bus.ex_rD2_o       = r_ex.rd2;
   assign id_bus.ex_ext_o       = r_ex.ext;
   assign id_bus.ex_rd_o        = r_ex.rd;
   assign id_bus.ex_wd_sel_o    = r_ex.wd_sel;
   assign id_bus.ex_we_o        = r_ex.we;
   assign id_bus.ex_mem_we_o    = r_ex.mem_we;
   assign id_bus.ex_alu_op_o    = r_ex.alu_op;
   assign id_bus.ex_alu_b_sel_o = r_ex.alu_b_sel;
   assign id_bus.ex_branch_o    = r_ex.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios followed by randomized traffic for id_ex_stage, checked
// against a behavioural model that tracks what instruction sits in EX and
// derives forwarding, stall and the next ID/EX contents from the rules.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam logic [6:0] T_OP_R     = 7'b0110011;
   localparam logic [6:0] T_OP_IALU  = 7'b0010011;
   localparam logic [6:0] T_OP_LOAD  = 7'b0000011;
   localparam logic [6:0] T_OP_LUI   = 7'b0110111;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [31:0] ex_result_i;
   logic [4:0]  mem_rd_i;
   logic        mem_we_i;
   logic [1:0]  mem_wd_sel_i;
   logic [31:0] mem_alu_result_i, mem_return_pc_i, mem_data_i;
   logic        flush_i;
   logic [31:0] forward_data_1_o, forward_data_2_o;
   logic        r1_select_o, r2_select_o, stall_o;
   logic [31:0] stall_cnt_o;

   int n_vec  = 0;
   int n_miss = 0;

   // Model of the instruction currently held in EX
   logic        m_valid, m_we, m_mem_we, m_b_sel, m_branch;
   logic [31:0] m_pc, m_rd1, m_rd2, m_ext, m_cnt;
   logic [4:0]  m_rd;
   logic [1:0]  m_wd_sel;
   logic [3:0]  m_alu_op;

   // Expected combinational outputs for the current inputs
   logic        e_sel1, e_sel2, e_stall;
   logic [31:0] e_d1, e_d2;

   logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                            7'b1100111};

   always #5 clk = ~clk;

   id_ex_if bus ();

   id_ex_stage dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .id_bus           (bus),
      .ex_result_i      (ex_result_i),
      .mem_rd_i         (mem_rd_i),
      .mem_we_i         (mem_we_i),
      .mem_wd_sel_i     (mem_wd_sel_i),
      .mem_alu_result_i (mem_alu_result_i),
      .mem_return_pc_i  (mem_return_pc_i),
      .mem_data_i       (mem_data_i),
      .flush_i          (flush_i),
      .forward_data_1_o (forward_data_1_o),
      .forward_data_2_o (forward_data_2_o),
      .r1_select_o      (r1_select_o),
      .r2_select_o      (r2_select_o),
      .stall_o          (stall_o),
      .stall_cnt_o      (stall_cnt_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, op};
   endfunction

   function automatic bit uses_rs1(input logic [6:0] op);
      return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
   endfunction

   function automatic bit uses_rs2(input logic [6:0] op);
      return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
   endfunction

   // What decode should see for one source register
   task automatic model_src(input logic [4:0] rs, input bit used,
                            output logic sel, output logic [31:0] data, output logic ld);
      sel = 1'b0; data = 32'd0; ld = 1'b0;
      if (used && m_valid && m_we && m_rd != 5'd0 && m_rd == rs) begin
         if (m_wd_sel == 2'b10) ld = 1'b1;
         else if (m_wd_sel == 2'b01) begin sel = 1'b1; data = ex_result_i; end
         else if (m_wd_sel == 2'b00) begin sel = 1'b1; data = m_pc + 32'd4; end
      end else if (used && mem_we_i && mem_rd_i != 5'd0 && mem_rd_i == rs) begin
         sel = 1'b1;
         if (mem_wd_sel_i == 2'b00)      data = mem_return_pc_i;
         else if (mem_wd_sel_i == 2'b01) data = mem_alu_result_i;
         else if (mem_wd_sel_i == 2'b10) data = mem_data_i;
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_we = 0; m_mem_we = 0; m_b_sel = 0; m_branch = 0;
      m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_ext = 0; m_rd = 0; m_wd_sel = 0;
      m_alu_op = 0; m_cnt = 0;
   endtask

   task automatic check_ex(input string tag);
      check({tag, ".valid"},  bus.ex_valid_o,     m_valid);
      check({tag, ".pc"},     bus.ex_pc_o,        m_pc);
      check({tag, ".rD1"},    bus.ex_rD1_o,       m_rd1);
      check({tag, ".rD2"},    bus.ex_rD2_o,       m_rd2);
      check({tag, ".ext"},    bus.ex_ext_o,       m_ext);
      check({tag, ".rd"},     bus.ex_rd_o,        m_rd);
      check({tag, ".wd_sel"}, bus.ex_wd_sel_o,    m_wd_sel);
      check({tag, ".we"},     bus.ex_we_o,        m_we);
      check({tag, ".mem_we"}, bus.ex_mem_we_o,    m_mem_we);
      check({tag, ".alu_op"}, bus.ex_alu_op_o,    m_alu_op);
      check({tag, ".b_sel"},  bus.ex_alu_b_sel_o, m_b_sel);
      check({tag, ".branch"}, bus.ex_branch_o,    m_branch);
      check({tag, ".cnt"},    stall_cnt_o,        m_cnt);
   endtask

   // Let inputs settle and compare the combinational outputs
   task automatic comb_check(input string tag);
      logic l1, l2;
      #1;
      model_src(bus.id_inst_i[19:15], uses_rs1(bus.id_inst_i[6:0]), e_sel1, e_d1, l1);
      model_src(bus.id_inst_i[24:20], uses_rs2(bus.id_inst_i[6:0]), e_sel2, e_d2, l2);
      e_stall = (l1 | l2) & !flush_i;
      check({tag, ".sel1"},  r1_select_o,      e_sel1);
      check({tag, ".fwd1"},  forward_data_1_o, e_d1);
      check({tag, ".sel2"},  r2_select_o,      e_sel2);
      check({tag, ".fwd2"},  forward_data_2_o, e_d2);
      check({tag, ".stall"}, stall_o,          e_stall);
   endtask

   // Advance one edge, update the model and compare the ID/EX register
   task automatic edge_check(input string tag);
      bit adv;
      adv = bus.id_valid_i && !flush_i && !e_stall;
      @(posedge clk);
      #1;
      m_valid  = adv;
      m_pc     = adv ? bus.id_pc_i : 32'd0;
      m_rd1    = adv ? (e_sel1 ? e_d1 : bus.id_rD1_i) : 32'd0;
      m_rd2    = adv ? (e_sel2 ? e_d2 : bus.id_rD2_i) : 32'd0;
      m_ext    = adv ? bus.id_ext_i : 32'd0;
      m_rd     = adv ? bus.id_inst_i[11:7] : 5'd0;
      m_wd_sel = adv ? bus.id_wd_sel_i : 2'd0;
      m_we     = adv ? bus.id_we_i : 1'b0;
      m_mem_we = adv ? bus.id_mem_we_i : 1'b0;
      m_alu_op = adv ? bus.id_alu_op_i : 4'd0;
      m_b_sel  = adv ? bus.id_alu_b_sel_i : 1'b0;
      m_branch = adv ? bus.id_branch_i : 1'b0;
      if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      check_ex(tag);
   endtask

   task automatic drive_id(input logic [31:0] inst, input logic [1:0] wd_sel,
                           input logic [31:0] pc);
      bus.id_valid_i     = 1'b1;
      bus.id_inst_i      = inst;
      bus.id_pc_i        = pc;
      bus.id_wd_sel_i    = wd_sel;
      bus.id_we_i        = 1'b1;
      bus.id_mem_we_i    = 1'b0;
      bus.id_rD1_i       = 32'hA000_0000 | pc;
      bus.id_rD2_i       = 32'hB000_0000 | pc;
      bus.id_ext_i       = 32'hC000_0000 | pc;
      bus.id_alu_op_i    = pc[5:2];
      bus.id_alu_b_sel_i = pc[2];
      bus.id_branch_i    = 1'b0;
   endtask

   initial begin
      reset_i = 1'b0;
      ex_result_i = 0; mem_rd_i = 0; mem_we_i = 0; mem_wd_sel_i = 0;
      mem_alu_result_i = 0; mem_return_pc_i = 0; mem_data_i = 0; flush_i = 0;
      bus.id_valid_i = 0; bus.id_pc_i = 0; bus.id_inst_i = 0; bus.id_rD1_i = 0;
      bus.id_rD2_i = 0; bus.id_ext_i = 0; bus.id_wd_sel_i = 0; bus.id_we_i = 0;
      bus.id_mem_we_i = 0; bus.id_alu_op_i = 0; bus.id_alu_b_sel_i = 0;
      bus.id_branch_i = 0;
      model_reset();
      #2;
      check_ex("reset");
      check("reset.stall", stall_o, 1'b0);
      @(negedge clk);
      reset_i = 1'b1;
      @(posedge clk);
      #1;

      // EX ALU producer forwards its result
      drive_id(mk(T_OP_R, 5'd5, 5'd1, 5'd2), 2'b01, 32'h100);
      comb_check("p_add5"); edge_check("p_add5");
      drive_id(mk(T_OP_R, 5'd6, 5'd5, 5'd1), 2'b01, 32'h104);
      ex_result_i = 32'h10;
      comb_check("ex_fwd");
      check("ex_fwd.sel1_k", r1_select_o, 1'b1);
      check("ex_fwd.data_k", forward_data_1_o, 32'h10);
      check("ex_fwd.stall_k", stall_o, 1'b0);
      edge_check("ex_fwd");

      // Load-use: one stall cycle, then MEM forwards the load data
      drive_id(mk(T_OP_LOAD, 5'd5, 5'd2, 5'd0), 2'b10, 32'h108);
      comb_check("p_lw5"); edge_check("p_lw5");
      drive_id(mk(T_OP_R, 5'd6, 5'd5, 5'd1), 2'b01, 32'h10C);
      comb_check("lu");
      check("lu.stall_k", stall_o, 1'b1);
      edge_check("lu");
      check("lu.valid_k", bus.ex_valid_o, 1'b0);
      check("lu.cnt_k", stall_cnt_o, 32'd1);
      mem_rd_i = 5'd5; mem_we_i = 1'b1; mem_wd_sel_i = 2'b10; mem_data_i = 32'hDEAD;
      comb_check("lu_mem");
      check("lu_mem.stall_k", stall_o, 1'b0);
      check("lu_mem.data_k", forward_data_1_o, 32'hDEAD);
      edge_check("lu_mem");
      check("lu_mem.rD1_k", bus.ex_rD1_o, 32'hDEAD);
      mem_we_i = 1'b0;

      // EX beats MEM for the same destination
      drive_id(mk(T_OP_R, 5'd7, 5'd1, 5'd2), 2'b01, 32'h200);
      comb_check("p_add7"); edge_check("p_add7");
      ex_result_i = 32'h1;
      mem_rd_i = 5'd7; mem_we_i = 1'b1; mem_wd_sel_i = 2'b01; mem_alu_result_i = 32'h2;
      drive_id(mk(T_OP_R, 5'd8, 5'd7, 5'd7), 2'b01, 32'h204);
      comb_check("prio");
      check("prio.data1_k", forward_data_1_o, 32'h1);
      check("prio.data2_k", forward_data_2_o, 32'h1);
      edge_check("prio");
      mem_we_i = 1'b0;

      // x0 never forwards; LUI does not read rs1
      drive_id(mk(T_OP_R, 5'd0, 5'd1, 5'd2), 2'b01, 32'h300);
      comb_check("p_x0"); edge_check("p_x0");
      drive_id(mk(T_OP_R, 5'd9, 5'd0, 5'd0), 2'b01, 32'h304);
      comb_check("x0");
      check("x0.sel1_k", r1_select_o, 1'b0);
      check("x0.sel2_k", r2_select_o, 1'b0);
      edge_check("x0");
      drive_id(mk(T_OP_IALU, 5'd3, 5'd1, 5'd0), 2'b01, 32'h308);
      comb_check("p_x3"); edge_check("p_x3");
      drive_id(mk(T_OP_LUI, 5'd4, 5'd3, 5'd3), 2'b01, 32'h30C);
      comb_check("lui");
      check("lui.sel1_k", r1_select_o, 1'b0);
      edge_check("lui");

      // Load-use coinciding with flush: no stall, bubble, count unchanged
      drive_id(mk(T_OP_LOAD, 5'd5, 5'd2, 5'd0), 2'b10, 32'h400);
      comb_check("p_lwf"); edge_check("p_lwf");
      drive_id(mk(T_OP_R, 5'd6, 5'd5, 5'd1), 2'b01, 32'h404);
      flush_i = 1'b1;
      comb_check("flush");
      check("flush.stall_k", stall_o, 1'b0);
      edge_check("flush");
      check("flush.valid_k", bus.ex_valid_o, 1'b0);
      check("flush.cnt_k", stall_cnt_o, 32'd1);
      flush_i = 1'b0;

      // Reset between edges in the middle of a stall
      drive_id(mk(T_OP_LOAD, 5'd5, 5'd2, 5'd0), 2'b10, 32'h500);
      comb_check("p_lwr"); edge_check("p_lwr");
      drive_id(mk(T_OP_R, 5'd6, 5'd5, 5'd1), 2'b01, 32'h504);
      comb_check("rst_mid");
      #1 reset_i = 1'b0;
      model_reset();
      #1;
      check_ex("rst_mid");
      check("rst_mid.stall", stall_o, 1'b0);
      #1 reset_i = 1'b1;
      comb_check("post_rst"); edge_check("post_rst");
      check("post_rst.valid_k", bus.ex_valid_o, 1'b1);

      // Randomized traffic over a small register window to force overlaps
      for (int i = 0; i < 300; i++) begin
         bus.id_valid_i     = ($urandom_range(9, 0) < 8);
         bus.id_inst_i      = mk(ops[$urandom_range(8, 0)], 5'($urandom_range(7, 0)),
                                 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
         bus.id_pc_i        = $urandom();
         bus.id_rD1_i       = $urandom();
         bus.id_rD2_i       = $urandom();
         bus.id_ext_i       = $urandom();
         bus.id_wd_sel_i    = 2'($urandom_range(2, 0));
         bus.id_we_i        = 1'($urandom_range(1, 0));
         bus.id_mem_we_i    = 1'($urandom_range(1, 0));
         bus.id_alu_op_i    = 4'($urandom_range(15, 0));
         bus.id_alu_b_sel_i = 1'($urandom_range(1, 0));
         bus.id_branch_i    = 1'($urandom_range(1, 0));
         ex_result_i        = $urandom();
         mem_rd_i           = 5'($urandom_range(7, 0));
         mem_we_i           = 1'($urandom_range(1, 0));
         mem_wd_sel_i       = 2'($urandom_range(2, 0));
         mem_alu_result_i   = $urandom();
         mem_return_pc_i    = $urandom();
         mem_data_i         = $urandom();
         flush_i            = ($urandom_range(9, 0) == 0);
         comb_check("rnd");
         edge_check("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
